// File: rtl/lotr_pkg.sv
// Shared ring-stop types: opcodes, the ring packet, and channel sizing.
package lotr_pkg;
  localparam int NUM_CH_MAX = 4;
  localparam int CH_W       = $clog2(NUM_CH_MAX);

  typedef enum logic [1:0] {
    RD     = 2'd0,
    WR     = 2'd1,
    RD_RSP = 2'd2,
    WR_RSP = 2'd3
  } t_opcode;

  typedef struct packed {
    logic        valid;
    logic [9:0]  requestor;
    t_opcode     opcode;
    logic [31:0] address;
    logic [31:0] data;
  } t_ring_pkt;
endpackage

// File: rtl/ring_fifo.sv
// Show-ahead packet FIFO: head is visible combinationally whenever not_empty.
module ring_fifo
  import lotr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      srst,
  input  logic      push,
  input  t_ring_pkt push_data,
  input  logic      pop,
  output t_ring_pkt head,
  output logic      not_full,
  output logic      not_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  t_ring_pkt        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  assign head      = mem[rd_ptr_reg];
  assign not_full  = (count_reg != CNT_FULL);
  assign not_empty = (count_reg != '0);
endmodule

// File: rtl/ring_stop_mc.sv
// Ring stop: 2-cycle pass-through on request/response rings, ejection to the
// local target/channels, and round-robin injection from per-channel FIFOs.
module ring_stop_mc
  import lotr_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              QClk,
  input  logic              RstQnnnH,
  input  logic [7:0]        CoreID,
  input  logic              RingReqInValidQ500H,
  input  logic [9:0]        RingReqInRequestorQ500H,
  input  t_opcode           RingReqInOpcodeQ500H,
  input  logic [31:0]       RingReqInAddressQ500H,
  input  logic [31:0]       RingReqInDataQ500H,
  input  logic              RingRspInValidQ500H,
  input  logic [9:0]        RingRspInRequestorQ500H,
  input  t_opcode           RingRspInOpcodeQ500H,
  input  logic [31:0]       RingRspInAddressQ500H,
  input  logic [31:0]       RingRspInDataQ500H,
  output logic              RingReqOutValidQ502H,
  output logic [9:0]        RingReqOutRequestorQ502H,
  output t_opcode           RingReqOutOpcodeQ502H,
  output logic [31:0]       RingReqOutAddressQ502H,
  output logic [31:0]       RingReqOutDataQ502H,
  output logic              RingRspOutValidQ502H,
  output logic [9:0]        RingRspOutRequestorQ502H,
  output t_opcode           RingRspOutOpcodeQ502H,
  output logic [31:0]       RingRspOutAddressQ502H,
  output logic [31:0]       RingRspOutDataQ502H,
  input  logic [NUM_CH-1:0] LclReqValid,
  input  t_opcode           LclReqOpcode  [NUM_CH],
  input  logic [31:0]       LclReqAddress [NUM_CH],
  input  logic [31:0]       LclReqData    [NUM_CH],
  output logic [NUM_CH-1:0] LclReqReady,
  output logic              TgtReqValid,
  output logic [9:0]        TgtReqRequestor,
  output t_opcode           TgtReqOpcode,
  output logic [31:0]       TgtReqAddress,
  output logic [31:0]       TgtReqData,
  input  logic              TgtReqReady,
  input  logic              TgtRspValid,
  input  logic [9:0]        TgtRspRequestor,
  input  t_opcode           TgtRspOpcode,
  input  logic [31:0]       TgtRspAddress,
  input  logic [31:0]       TgtRspData,
  output logic              TgtRspReady,
  output logic [NUM_CH-1:0] LclRspValid,
  output t_opcode           LclRspOpcode  [NUM_CH],
  output logic [31:0]       LclRspAddress [NUM_CH],
  output logic [31:0]       LclRspData    [NUM_CH]
);
  t_ring_pkt req_s1_reg, rsp_s1_reg;
  t_ring_pkt req_out_reg, req_out_next;
  t_ring_pkt rsp_out_reg, rsp_out_next;
  t_ring_pkt tgt_req_reg, tgt_req_next;
  t_ring_pkt lcl_rsp_reg, lcl_rsp_next;
  logic [CH_W-1:0] rr_ptr_reg, rr_ptr_next;

  t_ring_pkt         lcl_push_pkt [NUM_CH];
  t_ring_pkt         lcl_head     [NUM_CH];
  logic [NUM_CH-1:0] lcl_not_empty, lcl_pop;
  t_ring_pkt         rsp_push_pkt, rsp_head;
  logic              rsp_not_empty, rsp_pop;

  logic req_eject, req_free, rsp_eject, rsp_free, grant_valid;
  int   grant_ch;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign lcl_push_pkt[gi] = '{valid: 1'b1, requestor: {CoreID, CH_W'(gi)},
                                  opcode: LclReqOpcode[gi], address: LclReqAddress[gi],
                                  data: LclReqData[gi]};

      ring_fifo #(.DEPTH(FIFO_DEPTH)) u_lcl_fifo (
        .clk       (QClk),
        .srst      (RstQnnnH),
        .push      (LclReqValid[gi] && LclReqReady[gi]),
        .push_data (lcl_push_pkt[gi]),
        .pop       (lcl_pop[gi]),
        .head      (lcl_head[gi]),
        .not_full  (LclReqReady[gi]),
        .not_empty (lcl_not_empty[gi])
      );

      // lcl_rsp_reg is all-zero unless a deliverable response was ejected.
      logic sel;
      assign sel               = lcl_rsp_reg.valid && (lcl_rsp_reg.requestor[CH_W-1:0] == CH_W'(gi));
      assign LclRspValid[gi]   = sel;
      assign LclRspOpcode[gi]  = sel ? lcl_rsp_reg.opcode : RD;
      assign LclRspAddress[gi] = sel ? lcl_rsp_reg.address : '0;
      assign LclRspData[gi]    = sel ? lcl_rsp_reg.data : '0;
    end
  endgenerate

  assign rsp_push_pkt = '{valid: 1'b1, requestor: TgtRspRequestor, opcode: TgtRspOpcode,
                          address: TgtRspAddress, data: TgtRspData};

  ring_fifo #(.DEPTH(FIFO_DEPTH)) u_rsp_fifo (
    .clk       (QClk),
    .srst      (RstQnnnH),
    .push      (TgtRspValid && TgtRspReady),
    .push_data (rsp_push_pkt),
    .pop       (rsp_pop),
    .head      (rsp_head),
    .not_full  (TgtRspReady),
    .not_empty (rsp_not_empty)
  );

  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = 0;
    // Search from the pointer upward first, then wrap to the low channels.
    for (int j = 0; j < NUM_CH; j++) begin
      if (!grant_valid && lcl_not_empty[j] && (j >= int'(rr_ptr_reg))) begin
        grant_valid = 1'b1;
        grant_ch    = j;
      end
    end
    for (int j = 0; j < NUM_CH; j++) begin
      if (!grant_valid && lcl_not_empty[j] && (j < int'(rr_ptr_reg))) begin
        grant_valid = 1'b1;
        grant_ch    = j;
      end
    end
  end

  always_comb begin
    req_eject    = req_s1_reg.valid && (req_s1_reg.address[31:24] == CoreID) && TgtReqReady;
    req_free     = !req_s1_reg.valid || req_eject;
    tgt_req_next = req_eject ? req_s1_reg : '0;
    req_out_next = req_free ? '0 : req_s1_reg;
    lcl_pop      = '0;
    rr_ptr_next  = rr_ptr_reg;
    for (int k = 0; k < NUM_CH; k++) begin
      if (req_free && grant_valid && (grant_ch == k)) begin
        req_out_next = lcl_head[k];
        lcl_pop[k]   = 1'b1;
      end
    end
    if (req_free && grant_valid)
      rr_ptr_next = (grant_ch == NUM_CH - 1) ? '0 : CH_W'(grant_ch + 1);

    rsp_eject    = rsp_s1_reg.valid && (rsp_s1_reg.requestor[9:CH_W] == CoreID);
    rsp_free     = !rsp_s1_reg.valid || rsp_eject;
    rsp_pop      = rsp_free && rsp_not_empty;
    rsp_out_next = !rsp_free ? rsp_s1_reg : (rsp_pop ? rsp_head : '0);
    // Channel numbers beyond NUM_CH have no listener: the packet is dropped.
    lcl_rsp_next = (rsp_eject && (int'(rsp_s1_reg.requestor[CH_W-1:0]) < NUM_CH)) ? rsp_s1_reg : '0;
  end

  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      req_s1_reg  <= '0;
      rsp_s1_reg  <= '0;
      req_out_reg <= '0;
      rsp_out_reg <= '0;
      tgt_req_reg <= '0;
      lcl_rsp_reg <= '0;
      rr_ptr_reg  <= '0;
    end else begin
      req_s1_reg  <= '{valid: RingReqInValidQ500H, requestor: RingReqInRequestorQ500H,
                       opcode: RingReqInOpcodeQ500H, address: RingReqInAddressQ500H,
                       data: RingReqInDataQ500H};
      rsp_s1_reg  <= '{valid: RingRspInValidQ500H, requestor: RingRspInRequestorQ500H,
                       opcode: RingRspInOpcodeQ500H, address: RingRspInAddressQ500H,
                       data: RingRspInDataQ500H};
      req_out_reg <= req_out_next;
      rsp_out_reg <= rsp_out_next;
      tgt_req_reg <= tgt_req_next;
      lcl_rsp_reg <= lcl_rsp_next;
      rr_ptr_reg  <= rr_ptr_next;
    end
  end

  assign RingReqOutValidQ502H     = req_out_reg.valid;
  assign RingReqOutRequestorQ502H = req_out_reg.requestor;
  assign RingReqOutOpcodeQ502H    = req_out_reg.opcode;
  assign RingReqOutAddressQ502H   = req_out_reg.address;
  assign RingReqOutDataQ502H      = req_out_reg.data;
  assign RingRspOutValidQ502H     = rsp_out_reg.valid;
  assign RingRspOutRequestorQ502H = rsp_out_reg.requestor;
  assign RingRspOutOpcodeQ502H    = rsp_out_reg.opcode;
  assign RingRspOutAddressQ502H   = rsp_out_reg.address;
  assign RingRspOutDataQ502H      = rsp_out_reg.data;
  assign TgtReqValid              = tgt_req_reg.valid;
  assign TgtReqRequestor          = tgt_req_reg.requestor;
  assign TgtReqOpcode             = tgt_req_reg.opcode;
  assign TgtReqAddress            = tgt_req_reg.address;
  assign TgtReqData               = tgt_req_reg.data;
endmodule

// File: tb/tb_ring_stop_mc.sv
// Directed bench for ring_stop_mc: vector table for single-slot behaviour,
// hand sequences for injection order, back-pressure and reset.
module tb_ring_stop_mc;
  import lotr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  core_id;
  logic        rq_in_v, rs_in_v;
  logic [9:0]  rq_in_req, rs_in_req;
  t_opcode     rq_in_op, rs_in_op;
  logic [31:0] rq_in_addr, rq_in_data, rs_in_addr, rs_in_data;
  logic        rq_out_v, rs_out_v;
  logic [9:0]  rq_out_req, rs_out_req;
  t_opcode     rq_out_op, rs_out_op;
  logic [31:0] rq_out_addr, rq_out_data, rs_out_addr, rs_out_data;
  logic [3:0]  lcl_req_v, lcl_req_rdy, lcl_rsp_v;
  t_opcode     lcl_req_op [4];
  logic [31:0] lcl_req_addr [4], lcl_req_data [4];
  t_opcode     lcl_rsp_op [4];
  logic [31:0] lcl_rsp_addr [4], lcl_rsp_data [4];
  logic        tgt_req_v, tgt_req_rdy, tgt_rsp_v, tgt_rsp_rdy;
  logic [9:0]  tgt_req_req, tgt_rsp_req;
  t_opcode     tgt_req_op, tgt_rsp_op;
  logic [31:0] tgt_req_addr, tgt_req_data, tgt_rsp_addr, tgt_rsp_data;

  // Second stop with only two channels, used for out-of-range channel drops.
  logic [1:0]  d2_lcl_req_v, d2_lcl_req_rdy, d2_lcl_rsp_v;
  t_opcode     d2_lcl_req_op [2], d2_lcl_rsp_op [2];
  logic [31:0] d2_lcl_req_addr [2], d2_lcl_req_data [2], d2_lcl_rsp_addr [2], d2_lcl_rsp_data [2];
  logic        d2_rq_out_v, d2_rs_out_v, d2_tgt_req_v, d2_tgt_rsp_rdy;
  logic [9:0]  d2_rq_out_req, d2_rs_out_req, d2_tgt_req_req;
  t_opcode     d2_rq_out_op, d2_rs_out_op, d2_tgt_req_op;
  logic [31:0] d2_rq_out_addr, d2_rq_out_data, d2_rs_out_addr, d2_rs_out_data;
  logic [31:0] d2_tgt_req_addr, d2_tgt_req_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ring_stop_mc #(.NUM_CH(4), .FIFO_DEPTH(4)) u_dut (
    .QClk(clk), .RstQnnnH(rst), .CoreID(core_id),
    .RingReqInValidQ500H(rq_in_v), .RingReqInRequestorQ500H(rq_in_req), .RingReqInOpcodeQ500H(rq_in_op),
    .RingReqInAddressQ500H(rq_in_addr), .RingReqInDataQ500H(rq_in_data),
    .RingRspInValidQ500H(rs_in_v), .RingRspInRequestorQ500H(rs_in_req), .RingRspInOpcodeQ500H(rs_in_op),
    .RingRspInAddressQ500H(rs_in_addr), .RingRspInDataQ500H(rs_in_data),
    .RingReqOutValidQ502H(rq_out_v), .RingReqOutRequestorQ502H(rq_out_req), .RingReqOutOpcodeQ502H(rq_out_op),
    .RingReqOutAddressQ502H(rq_out_addr), .RingReqOutDataQ502H(rq_out_data),
    .RingRspOutValidQ502H(rs_out_v), .RingRspOutRequestorQ502H(rs_out_req), .RingRspOutOpcodeQ502H(rs_out_op),
    .RingRspOutAddressQ502H(rs_out_addr), .RingRspOutDataQ502H(rs_out_data),
    .LclReqValid(lcl_req_v), .LclReqOpcode(lcl_req_op), .LclReqAddress(lcl_req_addr),
    .LclReqData(lcl_req_data), .LclReqReady(lcl_req_rdy),
    .TgtReqValid(tgt_req_v), .TgtReqRequestor(tgt_req_req), .TgtReqOpcode(tgt_req_op),
    .TgtReqAddress(tgt_req_addr), .TgtReqData(tgt_req_data), .TgtReqReady(tgt_req_rdy),
    .TgtRspValid(tgt_rsp_v), .TgtRspRequestor(tgt_rsp_req), .TgtRspOpcode(tgt_rsp_op),
    .TgtRspAddress(tgt_rsp_addr), .TgtRspData(tgt_rsp_data), .TgtRspReady(tgt_rsp_rdy),
    .LclRspValid(lcl_rsp_v), .LclRspOpcode(lcl_rsp_op), .LclRspAddress(lcl_rsp_addr), .LclRspData(lcl_rsp_data)
  );

  ring_stop_mc #(.NUM_CH(2), .FIFO_DEPTH(4)) u_dut2 (
    .QClk(clk), .RstQnnnH(rst), .CoreID(core_id),
    .RingReqInValidQ500H(rq_in_v), .RingReqInRequestorQ500H(rq_in_req), .RingReqInOpcodeQ500H(rq_in_op),
    .RingReqInAddressQ500H(rq_in_addr), .RingReqInDataQ500H(rq_in_data),
    .RingRspInValidQ500H(rs_in_v), .RingRspInRequestorQ500H(rs_in_req), .RingRspInOpcodeQ500H(rs_in_op),
    .RingRspInAddressQ500H(rs_in_addr), .RingRspInDataQ500H(rs_in_data),
    .RingReqOutValidQ502H(d2_rq_out_v), .RingReqOutRequestorQ502H(d2_rq_out_req), .RingReqOutOpcodeQ502H(d2_rq_out_op),
    .RingReqOutAddressQ502H(d2_rq_out_addr), .RingReqOutDataQ502H(d2_rq_out_data),
    .RingRspOutValidQ502H(d2_rs_out_v), .RingRspOutRequestorQ502H(d2_rs_out_req), .RingRspOutOpcodeQ502H(d2_rs_out_op),
    .RingRspOutAddressQ502H(d2_rs_out_addr), .RingRspOutDataQ502H(d2_rs_out_data),
    .LclReqValid(d2_lcl_req_v), .LclReqOpcode(d2_lcl_req_op), .LclReqAddress(d2_lcl_req_addr),
    .LclReqData(d2_lcl_req_data), .LclReqReady(d2_lcl_req_rdy),
    .TgtReqValid(d2_tgt_req_v), .TgtReqRequestor(d2_tgt_req_req), .TgtReqOpcode(d2_tgt_req_op),
    .TgtReqAddress(d2_tgt_req_addr), .TgtReqData(d2_tgt_req_data), .TgtReqReady(tgt_req_rdy),
    .TgtRspValid(1'b0), .TgtRspRequestor(10'h0), .TgtRspOpcode(RD),
    .TgtRspAddress(32'h0), .TgtRspData(32'h0), .TgtRspReady(d2_tgt_rsp_rdy),
    .LclRspValid(d2_lcl_rsp_v), .LclRspOpcode(d2_lcl_rsp_op), .LclRspAddress(d2_lcl_rsp_addr), .LclRspData(d2_lcl_rsp_data)
  );

  typedef struct {
    logic        rq_v;
    logic [9:0]  rq_req;
    t_opcode     rq_op;
    logic [31:0] rq_addr;
    logic [31:0] rq_data;
    logic        tgt_rdy;
    logic        rs_v;
    logic [9:0]  rs_req;
    logic [31:0] rs_data;
    logic        e_tgt_v;
    logic        e_rq_out_v;
    logic [3:0]  e_lcl_mask;
    logic [1:0]  e_lcl_mask2;
    logic        e_rs_out_v;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_ring();
    rq_in_v = 1'b0; rq_in_req = '0; rq_in_op = RD; rq_in_addr = '0; rq_in_data = '0;
    rs_in_v = 1'b0; rs_in_req = '0; rs_in_op = RD; rs_in_addr = '0; rs_in_data = '0;
  endtask

  task automatic drive_foreign();
    rq_in_v = 1'b1; rq_in_req = 10'h1C0; rq_in_op = RD; rq_in_addr = 32'h0700_0000; rq_in_data = 32'h77;
    rs_in_v = 1'b1; rs_in_req = 10'h1C1; rs_in_op = RD_RSP; rs_in_addr = 32'h0700_0004; rs_in_data = 32'h88;
  endtask

  initial begin
    logic [31:0] lcl_or;
    // rq_v rq_req rq_op rq_addr rq_data tgt_rdy | rs_v rs_req rs_data | tgt_v rq_out_v lcl lcl2 rs_out_v
    vecs[0] = '{1'b1, 10'h014, WR,     32'h0300_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 10'h000, 32'h0,         1'b1, 1'b0, 4'b0000, 2'b00, 1'b0};
    vecs[1] = '{1'b1, 10'h014, WR,     32'h0300_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 10'h000, 32'h0,         1'b0, 1'b1, 4'b0000, 2'b00, 1'b0};
    vecs[2] = '{1'b1, 10'h020, RD,     32'h0500_0020, 32'h0000_1111, 1'b1, 1'b0, 10'h000, 32'h0,         1'b0, 1'b1, 4'b0000, 2'b00, 1'b0};
    vecs[3] = '{1'b0, 10'h000, RD,     32'h0,         32'h0,         1'b1, 1'b1, 10'h00E, 32'h1234_5678, 1'b0, 1'b0, 4'b0100, 2'b00, 1'b0};
    vecs[4] = '{1'b0, 10'h000, RD,     32'h0,         32'h0,         1'b1, 1'b1, 10'h010, 32'hAAAA_0000, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b1};
    vecs[5] = '{1'b0, 10'h000, RD,     32'h0,         32'h0,         1'b1, 1'b1, 10'h00C, 32'h0BAD_F00D, 1'b0, 1'b0, 4'b0001, 2'b01, 1'b0};
    vecs[6] = '{1'b1, 10'h018, RD,     32'h03FF_FFFC, 32'h5555_5555, 1'b1, 1'b1, 10'h00F, 32'hCAFE_F00D, 1'b1, 1'b0, 4'b1000, 2'b00, 1'b0};
    vecs[7] = '{1'b1, 10'h3FF, RD_RSP, 32'h0400_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 10'h000, 32'h0,         1'b0, 1'b1, 4'b0000, 2'b00, 1'b0};
    vecs[8] = '{1'b0, 10'h014, WR,     32'h0300_0010, 32'h0000_1234, 1'b1, 1'b0, 10'h00E, 32'h0000_9999, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0};

    core_id = 8'h03;
    rst = 1'b1;
    clear_ring();
    lcl_req_v = '0; d2_lcl_req_v = '0;
    for (int i = 0; i < 4; i++) begin
      lcl_req_op[i] = RD; lcl_req_addr[i] = '0; lcl_req_data[i] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      d2_lcl_req_op[i] = RD; d2_lcl_req_addr[i] = '0; d2_lcl_req_data[i] = '0;
    end
    tgt_req_rdy = 1'b1;
    tgt_rsp_v = 1'b0; tgt_rsp_req = '0; tgt_rsp_op = RD; tgt_rsp_addr = '0; tgt_rsp_data = '0;
    repeat (3) tick();
    chk("reset_rq_out_v", 32'(rq_out_v), 32'd0);
    chk("reset_rs_out_v", 32'(rs_out_v), 32'd0);
    chk("reset_tgt_req_v", 32'(tgt_req_v), 32'd0);
    chk("reset_lcl_rsp_v", 32'(lcl_rsp_v), 32'd0);
    chk("reset_rq_out_addr", rq_out_addr, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_reset_lcl_rdy", 32'(lcl_req_rdy), 32'hF);
    chk("post_reset_tgt_rsp_rdy", 32'(tgt_rsp_rdy), 32'd1);

    // Table: one packet per ring, two cycles to the outputs.
    for (int v = 0; v < 9; v++) begin
      rq_in_v = vecs[v].rq_v; rq_in_req = vecs[v].rq_req; rq_in_op = vecs[v].rq_op;
      rq_in_addr = vecs[v].rq_addr; rq_in_data = vecs[v].rq_data;
      rs_in_v = vecs[v].rs_v; rs_in_req = vecs[v].rs_req; rs_in_op = WR_RSP;
      rs_in_addr = 32'h0300_0000; rs_in_data = vecs[v].rs_data;
      tgt_req_rdy = vecs[v].tgt_rdy;
      tick();
      clear_ring();
      tick();
      lcl_or = '0;
      for (int c = 0; c < 4; c++) lcl_or |= lcl_rsp_data[c];
      chk($sformatf("v%0d_tgt_v", v), 32'(tgt_req_v), 32'(vecs[v].e_tgt_v));
      chk($sformatf("v%0d_tgt_req", v), 32'(tgt_req_req), vecs[v].e_tgt_v ? 32'(vecs[v].rq_req) : 32'd0);
      chk($sformatf("v%0d_tgt_data", v), tgt_req_data, vecs[v].e_tgt_v ? vecs[v].rq_data : 32'd0);
      chk($sformatf("v%0d_rq_out_v", v), 32'(rq_out_v), 32'(vecs[v].e_rq_out_v));
      chk($sformatf("v%0d_rq_out_addr", v), rq_out_addr, vecs[v].e_rq_out_v ? vecs[v].rq_addr : 32'd0);
      chk($sformatf("v%0d_rq_out_data", v), rq_out_data, vecs[v].e_rq_out_v ? vecs[v].rq_data : 32'd0);
      chk($sformatf("v%0d_rq_out_op", v), 32'(rq_out_op), vecs[v].e_rq_out_v ? 32'(vecs[v].rq_op) : 32'd0);
      chk($sformatf("v%0d_lcl_mask", v), 32'(lcl_rsp_v), 32'(vecs[v].e_lcl_mask));
      chk($sformatf("v%0d_lcl_data", v), lcl_or, (vecs[v].e_lcl_mask != 0) ? vecs[v].rs_data : 32'd0);
      chk($sformatf("v%0d_lcl_mask_2ch", v), 32'(d2_lcl_rsp_v), 32'(vecs[v].e_lcl_mask2));
      chk($sformatf("v%0d_rs_out_v", v), 32'(rs_out_v), 32'(vecs[v].e_rs_out_v));
      chk($sformatf("v%0d_rs_out_data", v), rs_out_data, vecs[v].e_rs_out_v ? vecs[v].rs_data : 32'd0);
      $display("vector %0d applied", v);
    end
    tgt_req_rdy = 1'b1;

    // All four channels push at once: injected 0,1,2,3 on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      lcl_req_addr[i] = 32'h0500_0000 + 32'(i * 16); lcl_req_data[i] = 32'(i);
    end
    lcl_req_v = 4'hF;
    tick();
    lcl_req_v = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr%0d_valid", i), 32'(rq_out_v), 32'd1);
      chk($sformatf("rr%0d_requestor", i), 32'(rq_out_req), 32'h00C + 32'(i));
      chk($sformatf("rr%0d_addr", i), rq_out_addr, 32'h0500_0000 + 32'(i * 16));
      $display("round-robin injection %0d requestor 0x%03h", i, rq_out_req);
    end
    tick();
    chk("rr_idle_after", 32'(rq_out_v), 32'd0);

    // Full ring: channel 1 fills its FIFO, nothing injects until a slot frees.
    drive_foreign();
    repeat (2) tick();
    for (int k = 0; k < 5; k++) begin
      lcl_req_v[1] = 1'b1; lcl_req_addr[1] = 32'h0500_0100 + 32'(k);
      tick();
      chk($sformatf("full_rdy_%0d", k), 32'(lcl_req_rdy[1]), (k < 3) ? 32'd1 : 32'd0);
      chk($sformatf("full_ring_owner_%0d", k), 32'(rq_out_req), 32'h1C0);
      $display("full-ring push attempt %0d ready=%0b", k, lcl_req_rdy[1]);
    end
    lcl_req_v = '0;
    tick();
    chk("full_ring_owner_hold", 32'(rq_out_req), 32'h1C0);
    clear_ring();
    tick();
    chk("full_ring_last_foreign", 32'(rq_out_req), 32'h1C0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("drain_%0d_req", k), 32'(rq_out_req), 32'h00D);
      chk($sformatf("drain_%0d_addr", k), rq_out_addr, 32'h0500_0100 + 32'(k));
      $display("drain injection %0d addr 0x%08h", k, rq_out_addr);
    end
    tick();
    chk("drain_done", 32'(rq_out_v), 32'd0);

    // Eject and inject in the same request slot.
    rq_in_v = 1'b1; rq_in_req = 10'h014; rq_in_op = WR; rq_in_addr = 32'h0300_0040; rq_in_data = 32'h4040;
    lcl_req_v[3] = 1'b1; lcl_req_addr[3] = 32'h0500_0300;
    tick();
    clear_ring();
    lcl_req_v = '0;
    tick();
    chk("swap_tgt_v", 32'(tgt_req_v), 32'd1);
    chk("swap_tgt_addr", tgt_req_addr, 32'h0300_0040);
    chk("swap_out_req", 32'(rq_out_req), 32'h00F);
    chk("swap_out_addr", rq_out_addr, 32'h0500_0300);
    $display("eject+inject slot: tgt 0x%08h ring 0x%08h", tgt_req_addr, rq_out_addr);

    // Target response injection onto an idle response ring.
    tgt_rsp_v = 1'b1; tgt_rsp_req = 10'h00D; tgt_rsp_op = WR_RSP;
    tgt_rsp_addr = 32'h0500_0000; tgt_rsp_data = 32'h2222;
    tick();
    tgt_rsp_v = 1'b0;
    tick();
    chk("tgt_rsp_inj_v", 32'(rs_out_v), 32'd1);
    chk("tgt_rsp_inj_req", 32'(rs_out_req), 32'h00D);
    chk("tgt_rsp_inj_data", rs_out_data, 32'h2222);
    $display("target response injected requestor 0x%03h", rs_out_req);

    // Reset with loaded ring and half-full FIFOs.
    drive_foreign();
    tick();
    lcl_req_v = 4'b0101; tgt_rsp_v = 1'b1;
    repeat (2) tick();
    lcl_req_v = '0; tgt_rsp_v = 1'b0;
    chk("prereset_rq_out_v", 32'(rq_out_v), 32'd1);
    chk("prereset_rdy", 32'(lcl_req_rdy), 32'hF);
    rst = 1'b1;
    tick();
    chk("midreset_rq_out_v", 32'(rq_out_v), 32'd0);
    chk("midreset_rq_out_addr", rq_out_addr, 32'd0);
    chk("midreset_rs_out_v", 32'(rs_out_v), 32'd0);
    chk("midreset_rs_out_data", rs_out_data, 32'd0);
    rst = 1'b0;
    clear_ring();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("postreset_%0d_rq_v", k), 32'(rq_out_v), 32'd0);
      chk($sformatf("postreset_%0d_rs_v", k), 32'(rs_out_v), 32'd0);
      $display("post-reset cycle %0d rq_v=%0b rs_v=%0b", k, rq_out_v, rs_out_v);
    end
    chk("postreset_rdy", 32'(lcl_req_rdy), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
